// File: rtl/ysyx_wbu_pkg.sv
// Shared helpers for the write-back/retire unit: queue geometry checks and sizing.
package ysyx_wbu_pkg;

  // Queue depth must be a power of two between 2 and 16.
  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Packed width of one queue entry: pc, inst, wdata, rd, wen, ebreak.
  function automatic int entry_w(input int xlen, input int ridx_w);
    return 3 * xlen + ridx_w + 2;
  endfunction

endpackage

// File: rtl/ysyx_wbu_rq_fifo.sv
// Generic DEPTH-entry circular buffer with push/pop/flush and a combinational head.
module ysyx_wbu_rq_fifo
  import ysyx_wbu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [PW:0]  count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      // A pop in the flush cycle has already been consumed by the reader.
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_reg] <= din;
  end

  assign dout  = mem[head_reg];
  assign count = count_reg;

endmodule

// File: rtl/ysyx_wbu_rq.sv
// In-order retire queue feeding the GPR write port; tracks last retired pc/inst,
// a wrapping retire counter, and freezes after an ebreak retires.
module ysyx_wbu_rq
  import ysyx_wbu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   inst,
  input  logic [RIDX_W-1:0] rd,
  input  logic [XLEN-1:0]   wdata,
  input  logic              wen,
  input  logic              ebreak,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic              flush,
  input  logic              rf_ready,
  output logic              rf_wen,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              retire_valid,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   inst_o,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halt_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("ysyx_wbu_rq: DEPTH must be a power of two in 2..16");
  end

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   wdata;
    logic              wen;
    logic              ebreak;
  } wb_entry_t;

  wb_entry_t        in_entry;
  wb_entry_t        head_entry;
  logic [PW:0]      q_count;
  logic             q_empty;
  logic             q_full;
  logic             push;
  logic             retire;
  logic             retire_ebreak;
  logic             q_flush;
  logic [PW:0]      count_next;
  logic             halt_next;
  logic             ready_next;

  logic             ready_reg;
  logic             halt_reg;
  logic [XLEN-1:0]  pc_reg;
  logic [XLEN-1:0]  inst_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign in_entry = '{pc: pc, inst: inst, rd: rd, wdata: wdata, wen: wen, ebreak: ebreak};

  assign push          = prev_valid && ready_reg && !q_full;
  assign retire        = !q_empty && rf_ready && !halt_reg;
  assign retire_ebreak = retire && head_entry.ebreak;
  // Retiring an ebreak discards everything younger, exactly like a flush.
  assign q_flush       = (flush && !halt_reg) || retire_ebreak;

  ysyx_wbu_rq_fifo #(
    .W     (entry_w(XLEN, RIDX_W)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_entry),
    .pop   (retire),
    .flush (q_flush),
    .dout  (head_entry),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    count_next = q_count;
    if (q_flush) begin
      count_next = '0;
    end else begin
      case ({push, retire})
        2'b10:   count_next = q_count + 1'b1;
        2'b01:   count_next = q_count - 1'b1;
        default: count_next = q_count;
      endcase
    end
    halt_next  = halt_reg || retire_ebreak;
    // Registered ready: a full queue that drains this cycle reopens next cycle.
    ready_next = !halt_next && (count_next < FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg <= 1'b0;
      halt_reg  <= 1'b0;
      pc_reg    <= '0;
      inst_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      ready_reg <= ready_next;
      halt_reg  <= halt_next;
      if (retire) begin
        pc_reg   <= head_entry.pc;
        inst_reg <= head_entry.inst;
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign rf_wen       = retire && head_entry.wen && (head_entry.rd != '0);
  assign rf_waddr     = head_entry.rd;
  assign rf_wdata     = head_entry.wdata;
  assign retire_valid = retire;
  assign ready_o      = ready_reg;
  assign halt_o       = halt_reg;
  assign pc_o         = pc_reg;
  assign inst_o       = inst_reg;
  assign retire_cnt   = cnt_reg;

endmodule

// File: tb/tb_ysyx_wbu_rq.sv
// Directed table-driven bench for ysyx_wbu_rq (DEPTH=4, CNT_W=4 so the counter wrap is reachable).
module tb_ysyx_wbu_rq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic [4:0]  rd = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        ebreak = 1'b0;
  logic        prev_valid = 1'b0;
  logic        ready_o;
  logic        flush = 1'b0;
  logic        rf_ready = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [3:0]  retire_cnt;
  logic        halt_o;

  int checks = 0;
  int errors = 0;

  ysyx_wbu_rq #(.XLEN(32), .DEPTH(4), .RIDX_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst), .rd(rd), .wdata(wdata),
    .wen(wen), .ebreak(ebreak), .prev_valid(prev_valid), .ready_o(ready_o),
    .flush(flush), .rf_ready(rf_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_valid(retire_valid), .pc_o(pc_o), .inst_o(inst_o),
    .retire_cnt(retire_cnt), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv, rfr, fl, wen, eb;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        e_rv, e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
    logic        e_halt;
  } vec_t;

  // Instruction word carried with each pc; the ebreak lives only at 0x80000010.
  function automatic logic [31:0] mk_inst(input logic [31:0] p);
    if (p == 32'h0) return 32'h0;
    if (p == 32'h8000_0010) return 32'h0010_0073;
    return p ^ 32'h0000_0013;
  endfunction

  function automatic vec_t v(input logic pv, input logic rfr, input logic fl,
                             input logic [31:0] pc_i, input logic [4:0] rd_i,
                             input logic [31:0] wd, input logic wen_i, input logic eb,
                             input logic erv, input logic ewen, input logic [4:0] eaddr,
                             input logic [31:0] edata, input logic erdy,
                             input logic [31:0] epc, input logic [3:0] ecnt, input logic ehalt);
    vec_t t;
    t.pv = pv; t.rfr = rfr; t.fl = fl; t.pc = pc_i; t.rd = rd_i; t.wd = wd;
    t.wen = wen_i; t.eb = eb; t.e_rv = erv; t.e_wen = ewen; t.e_addr = eaddr;
    t.e_data = edata; t.e_rdy = erdy; t.e_pc = epc; t.e_cnt = ecnt; t.e_halt = ehalt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
    end
  endtask

  // Drive one cycle: combinational outputs checked before the edge, state after it.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    prev_valid = t.pv; rf_ready = t.rfr; flush = t.fl; pc = t.pc; inst = mk_inst(t.pc);
    rd = t.rd; wdata = t.wd; wen = t.wen; ebreak = t.eb;
    #1;
    chk({tag, " retire_valid"}, 32'(retire_valid), 32'(t.e_rv));
    chk({tag, " rf_wen"}, 32'(rf_wen), 32'(t.e_wen));
    chk({tag, " ready_o"}, 32'(ready_o), 32'(t.e_rdy));
    if (t.e_rv) begin
      chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(t.e_addr));
      chk({tag, " rf_wdata"}, rf_wdata, t.e_data);
    end
    @(posedge clk);
    #1;
    chk({tag, " pc_o"}, pc_o, t.e_pc);
    chk({tag, " inst_o"}, inst_o, mk_inst(t.e_pc));
    chk({tag, " retire_cnt"}, 32'(retire_cnt), 32'(t.e_cnt));
    chk({tag, " halt_o"}, 32'(halt_o), 32'(t.e_halt));
    $display("txn %s: pv=%0b rfr=%0b fl=%0b pc=%h -> rv=%0b wen=%0b pc_o=%h cnt=%0d halt=%0b",
             tag, t.pv, t.rfr, t.fl, t.pc, retire_valid, rf_wen, pc_o, retire_cnt, halt_o);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rf_wen"}, 32'(rf_wen), 32'h0);
    chk({tag, " retire_valid"}, 32'(retire_valid), 32'h0);
    chk({tag, " ready_o"}, 32'(ready_o), 32'h0);
    chk({tag, " pc_o"}, pc_o, 32'h0);
    chk({tag, " inst_o"}, inst_o, 32'h0);
    chk({tag, " retire_cnt"}, 32'(retire_cnt), 32'h0);
    chk({tag, " halt_o"}, 32'(halt_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t seg_a[$];
    vec_t seg_e[$];
    vec_t t;

    // Single entry, full queue with ordered drain, rd=0, back-to-back, wen=0, flush.
    seg_a.push_back(v(1,1,0,32'h80000000,5,32'h1234,1,0, 0,0,0,0,1, 32'h0,0,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,1,5,32'h1234,1, 32'h80000000,1,0));
    seg_a.push_back(v(1,0,0,32'h80000004,1,32'hA1,1,0, 0,0,0,0,1, 32'h80000000,1,0));
    seg_a.push_back(v(1,0,0,32'h80000008,2,32'hA2,1,0, 0,0,0,0,1, 32'h80000000,1,0));
    seg_a.push_back(v(1,0,0,32'h8000000C,3,32'hA3,1,0, 0,0,0,0,1, 32'h80000000,1,0));
    seg_a.push_back(v(1,0,0,32'h80000014,4,32'hA4,1,0, 0,0,0,0,1, 32'h80000000,1,0));
    seg_a.push_back(v(1,1,0,32'h80000018,6,32'hBAD,1,0, 1,1,1,32'hA1,0, 32'h80000004,2,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,1,2,32'hA2,1, 32'h80000008,3,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,1,3,32'hA3,1, 32'h8000000C,4,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,1,4,32'hA4,1, 32'h80000014,5,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           0,0,0,0,1, 32'h80000014,5,0));
    seg_a.push_back(v(1,1,0,32'h80000020,0,32'h55,1,0, 0,0,0,0,1, 32'h80000014,5,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,0,0,32'h55,1, 32'h80000020,6,0));
    seg_a.push_back(v(1,1,0,32'h80000024,7,32'h77,1,0, 0,0,0,0,1, 32'h80000020,6,0));
    seg_a.push_back(v(1,1,0,32'h80000028,8,32'h88,1,0, 1,1,7,32'h77,1, 32'h80000024,7,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,1,8,32'h88,1, 32'h80000028,8,0));
    seg_a.push_back(v(1,1,0,32'h8000002C,9,32'h99,0,0, 0,0,0,0,1, 32'h80000028,8,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           1,0,9,32'h99,1, 32'h8000002C,9,0));
    seg_a.push_back(v(1,0,0,32'h80000030,10,32'hB0,1,0, 0,0,0,0,1, 32'h8000002C,9,0));
    seg_a.push_back(v(1,0,0,32'h80000034,11,32'hB1,1,0, 0,0,0,0,1, 32'h8000002C,9,0));
    seg_a.push_back(v(1,0,0,32'h80000038,12,32'hB2,1,0, 0,0,0,0,1, 32'h8000002C,9,0));
    seg_a.push_back(v(1,1,1,32'h8000003C,13,32'hB3,1,0, 1,1,10,32'hB0,1, 32'h80000030,10,0));
    seg_a.push_back(v(0,1,0,32'h0,0,0,0,0,           0,0,0,0,1, 32'h80000030,10,0));

    // Ebreak in the middle of {A, ebreak, C}, then halted behaviour.
    seg_e.push_back(v(1,0,0,32'h80000040,14,32'hC0,1,0, 0,0,0,0,1, 32'h80000118,1,0));
    seg_e.push_back(v(1,0,0,32'h80000010,0,32'h0,0,1,   0,0,0,0,1, 32'h80000118,1,0));
    seg_e.push_back(v(1,0,0,32'h80000044,15,32'hC2,1,0, 0,0,0,0,1, 32'h80000118,1,0));
    seg_e.push_back(v(0,1,0,32'h0,0,0,0,0,             1,1,14,32'hC0,1, 32'h80000040,2,0));
    seg_e.push_back(v(1,1,0,32'h80000048,16,32'hD0,1,0, 1,0,0,32'h0,1, 32'h80000010,3,1));
    seg_e.push_back(v(1,1,0,32'h8000004C,17,32'hD1,1,0, 0,0,0,0,0, 32'h80000010,3,1));
    seg_e.push_back(v(1,1,1,32'h80000050,18,32'hD2,1,0, 0,0,0,0,0, 32'h80000010,3,1));
    seg_e.push_back(v(0,1,0,32'h0,0,0,0,0,             0,0,0,0,0, 32'h80000010,3,1));

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (seg_a[i]) apply(seg_a[i], $sformatf("a%0d", i));

    // Streamed push+retire each cycle; the 4-bit counter passes 15 -> 0 -> 1.
    for (int i = 0; i < 8; i++) begin
      t = v((i < 7) ? 1'b1 : 1'b0, 1'b1, 1'b0, 32'h80000100 + 32'(4 * i), 5'(i + 1),
            32'hC00 + 32'(i), 1'b1, 1'b0,
            (i > 0) ? 1'b1 : 1'b0, (i > 0) ? 1'b1 : 1'b0, 5'(i), 32'hC00 + 32'(i) - 32'h1, 1'b1,
            (i > 0) ? 32'h80000100 + 32'(4 * (i - 1)) : 32'h80000030,
            4'((10 + i) % 16), 1'b0);
      apply(t, $sformatf("w%0d", i));
    end

    foreach (seg_e[i]) apply(seg_e[i], $sformatf("e%0d", i));

    // Reset clears halt, then an in-flight write is aborted by an asynchronous reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(v(1,1,0,32'h80000050,3,32'hDEAD,1,0, 0,0,0,0,1, 32'h0,0,0), "r0");
    apply(v(1,1,0,32'h80000054,4,32'hBEEF,1,0, 1,1,3,32'hDEAD,1, 32'h80000050,1,0), "r1");
    @(negedge clk);
    prev_valid = 1'b0; rf_ready = 1'b1; flush = 1'b0;
    #1;
    chk("r2 rf_wen before reset", 32'(rf_wen), 32'h1);
    chk("r2 rf_waddr before reset", 32'(rf_waddr), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    $display("txn async reset: rf_wen=%0b pc_o=%h cnt=%0d", rf_wen, pc_o, retire_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    apply(v(0,1,0,32'h0,0,0,0,0, 0,0,0,0,1, 32'h0,0,0), "r3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
